// File: rtl/sram_rw_port_ctrl.sv
// Front-end for a single-port RW0 SRAM macro: serialises write/read requests onto the
// port, zero-sweeps the array after reset and returns read data through a 2-entry buffer.
module sram_rw_port_ctrl #(
  parameter int unsigned ADDR_W        = 1,
  parameter int unsigned DATA_W        = 96,
  parameter int unsigned MASK_W        = 2,
  parameter int unsigned INIT_ON_RESET = 1,
  parameter int unsigned WR_STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [MASK_W-1:0] wreq_mask,
  input  logic [DATA_W-1:0] wreq_data,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [DATA_W-1:0] rresp_data,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int unsigned StarveW = $clog2(WR_STARVE_MAX + 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic                r_init_done;
  logic [StarveW-1:0]  r_starve;
  logic                r_inflight;
  logic [1:0]          r_count;
  logic                r_wptr;
  logic                r_rptr;
  logic [DATA_W-1:0]   r_buf [2];

  logic                w_run;
  logic                w_rd_elig;
  logic                w_starved;
  logic                w_wr_gnt;
  logic                w_rd_gnt;
  logic                w_push;
  logic                w_pop;
  logic                w_en;

  // Init sweep and run-state tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= (INIT_ON_RESET != 0) ? StInit : StRun;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_init_cnt <= r_init_cnt + ADDR_W'(1);
          if (&r_init_cnt) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StRun: r_init_done <= 1'b1;
        default: r_state <= StInit;
      endcase
    end
  end

  assign w_run = (r_state == StRun) && r_init_done;

  // Read credit counts the in-flight slot; a same-cycle pop does not free a slot.
  assign w_rd_elig = (r_count + {1'b0, r_inflight}) < 2'd2;
  assign w_starved = (r_starve == StarveW'(WR_STARVE_MAX)) && rreq_valid && w_rd_elig;
  assign w_wr_gnt  = w_run && wreq_valid && !w_starved;
  assign w_rd_gnt  = w_run && rreq_valid && w_rd_elig && !w_wr_gnt;

  assign wreq_ready = w_wr_gnt;
  assign rreq_ready = w_rd_gnt;
  assign init_done  = r_init_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (!w_run || w_rd_gnt || !rreq_valid) begin
      r_starve <= '0;
    end else if (w_wr_gnt && w_rd_elig && (r_starve != StarveW'(WR_STARVE_MAX))) begin
      r_starve <= r_starve + StarveW'(1);
    end
  end

  // Macro returns data one cycle after the read command; capture it at the end of that cycle.
  assign w_push = r_inflight;
  assign w_pop  = (r_count != 2'd0) && rresp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
    end else begin
      r_inflight <= w_rd_gnt;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_buf[r_wptr] <= RW0_rdata;
  end

  assign rresp_valid = (r_count != 2'd0);
  assign rresp_data  = r_buf[r_rptr];

  always_comb begin
    w_en      = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (r_state == StInit) begin
      w_en      = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = r_init_cnt;
      RW0_wmask = '1;
    end else if (w_wr_gnt) begin
      w_en      = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = wreq_addr;
      RW0_wmask = wreq_mask;
      RW0_wdata = wreq_data;
    end else if (w_rd_gnt) begin
      w_en      = 1'b1;
      RW0_addr  = rreq_addr;
    end
  end

  // The reset state is StInit, so the enable must also be held off while reset is low.
  assign RW0_en = w_en && reset;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural RW0 macro (registered read, lane mask).
module tb_sram_rw_port_ctrl;
  localparam int unsigned AW = 1;
  localparam int unsigned DW = 96;
  localparam int unsigned MW = 2;

  localparam logic [DW-1:0] D0 = {48'h1234_5678_9ABC, 48'h0};
  localparam logic [DW-1:0] D1 = {48'h0, 48'h0ABC};

  logic          clock = 1'b0;
  logic          reset;
  logic          init_done;
  logic          wreq_valid, wreq_ready;
  logic [AW-1:0] wreq_addr;
  logic [MW-1:0] wreq_mask;
  logic [DW-1:0] wreq_data;
  logic          rreq_valid, rreq_ready;
  logic [AW-1:0] rreq_addr;
  logic          rresp_valid, rresp_ready;
  logic [DW-1:0] rresp_data;
  logic          RW0_en, RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_rw_port_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .init_done   (init_done),
    .wreq_valid  (wreq_valid),
    .wreq_ready  (wreq_ready),
    .wreq_addr   (wreq_addr),
    .wreq_mask   (wreq_mask),
    .wreq_data   (wreq_data),
    .rreq_valid  (rreq_valid),
    .rreq_ready  (rreq_ready),
    .rreq_addr   (rreq_addr),
    .rresp_valid (rresp_valid),
    .rresp_ready (rresp_ready),
    .rresp_data  (rresp_data),
    .RW0_en      (RW0_en),
    .RW0_wmode   (RW0_wmode),
    .RW0_addr    (RW0_addr),
    .RW0_wmask   (RW0_wmask),
    .RW0_wdata   (RW0_wdata),
    .RW0_rdata   (RW0_rdata)
  );

  // Macro model, preloaded with ones so the zero sweep is observable.
  logic [DW-1:0] mem [2] = '{default: '1};
  logic [DW-1:0] mem_rdata = '0;
  assign RW0_rdata = mem_rdata;

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < int'(MW); l++) begin
          if (RW0_wmask[l]) mem[RW0_addr][l*48 +: 48] <= RW0_wdata[l*48 +: 48];
        end
      end else begin
        mem_rdata <= mem[RW0_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wreq_valid = 1'b1; rreq_valid = 1'b1; rresp_ready = 1'b0;
    wreq_addr = '0; wreq_mask = '0; wreq_data = '0; rreq_addr = '0;
    repeat (3) tick();
    #2;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %0b exp 0", init_done); end
    checks++; if (wreq_ready !== 1'b0) begin errors++; $display("FAIL rst_wready got %0b exp 0", wreq_ready); end
    checks++; if (rreq_ready !== 1'b0) begin errors++; $display("FAIL rst_rready got %0b exp 0", rreq_ready); end
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b exp 0", rresp_valid); end
    checks++; if (RW0_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0b exp 0", RW0_en); end
    wreq_valid = 1'b0;
    tick(); reset = 1'b1; #2;
    checks++; if ({RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== 5'b11011) begin
      errors++; $display("FAIL init0_cmd got %b exp 11011", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}); end
    checks++; if (RW0_wdata !== '0) begin errors++; $display("FAIL init0_wdata got %h exp 0", RW0_wdata); end
    checks++; if ({init_done, rreq_ready} !== 2'b00) begin
      errors++; $display("FAIL init0_flags got %b exp 00", {init_done, rreq_ready}); end
    tick(); #2;
    checks++; if ({RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== 5'b11111) begin
      errors++; $display("FAIL init1_cmd got %b exp 11111", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}); end
    checks++; if ({init_done, rreq_ready} !== 2'b00) begin
      errors++; $display("FAIL init1_flags got %b exp 00", {init_done, rreq_ready}); end
    tick(); rreq_addr = 1'b1; #2;
    checks++; if ({init_done, rreq_ready} !== 2'b11) begin
      errors++; $display("FAIL run_flags got %b exp 11", {init_done, rreq_ready}); end
    checks++; if ({RW0_en, RW0_wmode, RW0_addr} !== 3'b101) begin
      errors++; $display("FAIL run_rd_cmd got %b exp 101", {RW0_en, RW0_wmode, RW0_addr}); end
    tick(); rreq_valid = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1 got %0b exp 0", rresp_valid); end
    tick(); rresp_ready = 1'b1; #2;
    checks++; if (rresp_valid !== 1'b1) begin errors++; $display("FAIL rd_lat2 got %0b exp 1", rresp_valid); end
    checks++; if (rresp_data !== '0) begin errors++; $display("FAIL init_data got %h exp 0", rresp_data); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL rd_popped got %0b exp 0", rresp_valid); end
  endtask

  task automatic test_mask_write();
    tick();
    wreq_valid = 1'b1; wreq_addr = 1'b1; wreq_mask = 2'b01; wreq_data = {48'hDEAD_0000_BEEF, 48'h0ABC};
    #2;
    checks++; if ({wreq_ready, RW0_wmode, RW0_wmask} !== 4'b1101) begin
      errors++; $display("FAIL wr_lo_cmd got %b exp 1101", {wreq_ready, RW0_wmode, RW0_wmask}); end
    tick(); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 1'b1; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL raw_rready got %0b exp 1", rreq_ready); end
    tick(); rreq_valid = 1'b0; #2;
    tick(); rresp_ready = 1'b1; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D1}) begin
      errors++; $display("FAIL wr_lo_data got %b/%h exp 1/%h", rresp_valid, rresp_data, D1); end
    tick(); rresp_ready = 1'b0;
    wreq_valid = 1'b1; wreq_addr = 1'b0; wreq_mask = 2'b10; wreq_data = {48'h1234_5678_9ABC, 48'h0FFF};
    #2;
    checks++; if (wreq_ready !== 1'b1) begin errors++; $display("FAIL wr_hi_ready got %0b exp 1", wreq_ready); end
    tick(); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 1'b0; #2;
    tick(); rreq_valid = 1'b0; #2;
    tick(); rresp_ready = 1'b1; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D0}) begin
      errors++; $display("FAIL wr_hi_data got %b/%h exp 1/%h", rresp_valid, rresp_data, D0); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL wr_hi_pop got %0b exp 0", rresp_valid); end
  endtask

  task automatic test_backpressure();
    tick(); rreq_valid = 1'b1; rreq_addr = 1'b0; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL bp_rd0 got %0b exp 1", rreq_ready); end
    tick(); rreq_addr = 1'b1; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL bp_rd1 got %0b exp 1", rreq_ready); end
    tick(); rreq_addr = 1'b0; #2;
    checks++; if (rreq_ready !== 1'b0) begin errors++; $display("FAIL bp_rd2_c3 got %0b exp 0", rreq_ready); end
    checks++; if (rresp_data !== D0) begin errors++; $display("FAIL bp_head0 got %h exp %h", rresp_data, D0); end
    tick(); #2;
    checks++; if (rreq_ready !== 1'b0) begin errors++; $display("FAIL bp_rd2_c4 got %0b exp 0", rreq_ready); end
    tick(); rresp_ready = 1'b1; #2;
    checks++; if (rreq_ready !== 1'b0) begin errors++; $display("FAIL bp_no_credit got %0b exp 0", rreq_ready); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL bp_rd2_go got %0b exp 1", rreq_ready); end
    checks++; if (rresp_data !== D1) begin errors++; $display("FAIL bp_head1 got %h exp %h", rresp_data, D1); end
    tick(); rreq_valid = 1'b0; #2;
    tick(); rresp_ready = 1'b1; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D1}) begin
      errors++; $display("FAIL bp_out1 got %b/%h exp 1/%h", rresp_valid, rresp_data, D1); end
    tick(); #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D0}) begin
      errors++; $display("FAIL bp_out2 got %b/%h exp 1/%h", rresp_valid, rresp_data, D0); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", rresp_valid); end
  endtask

  task automatic test_starve();
    logic [9:0] pat_w;
    pat_w = 10'b01111_01111;  // bit i = write granted in cycle i
    tick();
    wreq_valid = 1'b1; wreq_addr = 1'b1; wreq_mask = 2'b00; wreq_data = '0;
    rreq_valid = 1'b1; rreq_addr = 1'b0; rresp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick();
      #2;
      checks++;
      if ({wreq_ready, rreq_ready} !== {pat_w[i], ~pat_w[i]}) begin
        errors++;
        $display("FAIL starve_c%0d got w%0b r%0b exp w%0b r%0b", i, wreq_ready, rreq_ready,
                 pat_w[i], ~pat_w[i]);
      end
    end
    tick(); wreq_valid = 1'b0; rreq_valid = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL starve_gap got %0b exp 0", rresp_valid); end
    tick(); #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D0}) begin
      errors++; $display("FAIL starve_data got %b/%h exp 1/%h", rresp_valid, rresp_data, D0); end
    tick(); rresp_ready = 1'b0; #2;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat_r;
    pat_r = 6'b011_011;  // bit i = read granted in cycle i
    tick(); rreq_valid = 1'b1; rreq_addr = 1'b1; rresp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      #2;
      checks++;
      if (rreq_ready !== pat_r[i]) begin
        errors++; $display("FAIL b2b_c%0d got %0b exp %0b", i, rreq_ready, pat_r[i]);
      end
    end
    tick(); rreq_valid = 1'b0; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D1}) begin
      errors++; $display("FAIL b2b_last got %b/%h exp 1/%h", rresp_valid, rresp_data, D1); end
    tick(); #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", rresp_valid); end
    tick(); rresp_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    tick(); rreq_valid = 1'b1; rreq_addr = 1'b0; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL pp_rd0 got %0b exp 1", rreq_ready); end
    tick(); rreq_addr = 1'b1; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL pp_rd1 got %0b exp 1", rreq_ready); end
    tick(); rreq_valid = 1'b0; rresp_ready = 1'b1; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D0}) begin
      errors++; $display("FAIL pp_first got %b/%h exp 1/%h", rresp_valid, rresp_data, D0); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, D1}) begin
      errors++; $display("FAIL pp_second got %b/%h exp 1/%h", rresp_valid, rresp_data, D1); end
    tick(); rresp_ready = 1'b1; #2;
    checks++; if (rresp_valid !== 1'b1) begin errors++; $display("FAIL pp_held got %0b exp 1", rresp_valid); end
    tick(); rresp_ready = 1'b0; #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL pp_occ1 got %0b exp 0", rresp_valid); end
  endtask

  task automatic test_reset_midop();
    tick(); rreq_valid = 1'b1; rreq_addr = 1'b0; #2;
    checks++; if (rreq_ready !== 1'b1) begin errors++; $display("FAIL mid_rd got %0b exp 1", rreq_ready); end
    tick(); rreq_valid = 1'b0; reset = 1'b0; #2;
    checks++; if ({rresp_valid, init_done, RW0_en} !== 3'b000) begin
      errors++; $display("FAIL mid_rst got %b exp 000", {rresp_valid, init_done, RW0_en}); end
    tick(); tick(); #2;
    checks++; if (rresp_valid !== 1'b0) begin errors++; $display("FAIL mid_hold got %0b exp 0", rresp_valid); end
    tick(); reset = 1'b1; #2;
    checks++; if ({init_done, RW0_en, RW0_wmode, RW0_addr, rresp_valid} !== 5'b01100) begin
      errors++; $display("FAIL mid_init0 got %b exp 01100",
                         {init_done, RW0_en, RW0_wmode, RW0_addr, rresp_valid}); end
    tick(); #2;
    checks++; if ({init_done, RW0_en, RW0_wmode, RW0_addr, rresp_valid} !== 5'b01110) begin
      errors++; $display("FAIL mid_init1 got %b exp 01110",
                         {init_done, RW0_en, RW0_wmode, RW0_addr, rresp_valid}); end
    tick(); rreq_valid = 1'b1; rreq_addr = 1'b0; #2;
    checks++; if ({init_done, rresp_valid, rreq_ready} !== 3'b101) begin
      errors++; $display("FAIL mid_run got %b exp 101", {init_done, rresp_valid, rreq_ready}); end
    tick(); rreq_valid = 1'b0; #2;
    tick(); rresp_ready = 1'b1; #2;
    checks++; if ({rresp_valid, rresp_data} !== {1'b1, {DW{1'b0}}}) begin
      errors++; $display("FAIL mid_rezero got %b/%h exp 1/0", rresp_valid, rresp_data); end
    tick(); rresp_ready = 1'b0; #2;
  endtask

  initial begin
    test_reset();
    test_mask_write();
    test_backpressure();
    test_starve();
    test_back_to_back();
    test_push_pop();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
